// File: rtl/column_draw_pkg.sv
// Shared column-rendering constants and encodings, also used by cast_ray and the
// framebuffer writer.
package column_draw_pkg;

   localparam int SCREEN_H = 240;
   localparam int TEX_SIZE = 128;
   localparam int TEX_BITS = 7;

   localparam logic [7:0] CEIL_COLOR  = 8'h11;
   localparam logic [7:0] FLOOR_COLOR = 8'h22;

   localparam logic [7:0]          HALF_H        = 8'(SCREEN_H / 2);
   localparam logic [7:0]          LAST_ROW      = 8'(SCREEN_H - 1);
   localparam logic [23:0]         STEP_DIVIDEND = 24'(TEX_SIZE << 16);
   localparam logic [TEX_BITS-1:0] TEX_Y_MAX     = TEX_BITS'(TEX_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIV   = 2'd1,
      SETUP = 2'd2,
      EMIT  = 2'd3
   } column_state_t;

   typedef enum logic [1:0] {
      KIND_CEIL  = 2'd0,
      KIND_WALL  = 2'd1,
      KIND_FLOOR = 2'd2
   } row_kind_t;

endpackage

// File: rtl/column_step_div.sv
// Radix-2 restoring divider: 24-bit dividend / 16-bit divisor, one quotient bit per
// cycle, done pulses once the quotient is final. The quotient holds until the next start.
module column_step_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] dividend,
   input  logic [15:0] divisor,
   output logic        done,
   output logic [23:0] quotient
);

   logic [15:0] rem_q;
   logic [15:0] div_q;
   logic [4:0]  cnt_q;
   logic        run_q;
   logic [16:0] trial;
   logic        ge;
   logic [15:0] diff;

   // quotient doubles as the dividend shift register; quotient bits enter at the LSB
   assign trial = {rem_q, quotient[23]};
   assign ge    = trial >= {1'b0, div_q};
   assign diff  = trial[15:0] - div_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q    <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         done     <= 1'b0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem_q    <= '0;
            div_q    <= divisor;
            quotient <= dividend;
            cnt_q    <= 5'd24;
            run_q    <= 1'b1;
         end else if (run_q) begin
            rem_q    <= ge ? diff : trial[15:0];
            quotient <= {quotient[22:0], ge};
            cnt_q    <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               run_q <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/column_draw.sv
// Streams one screen column (ceiling, textured wall, floor) to the framebuffer writer.
// Three-stage pipeline: address (tex_addr), ROM wait, pixel output register.
module column_draw
   import column_draw_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [8:0]    x,
   input  logic [23:0]   line_height,
   input  logic [7:0]    line_color,
   input  logic [6:0]    line_tex_x,
   output logic          busy,
   output logic [15:0]   tex_addr,
   input  logic [7:0]    tex_data,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [8:0]    pix_x,
   output logic [7:0]    pix_y,
   output logic [7:0]    pix_color,
   output column_state_t dbg_state
);

   // Handshake: a pixel transfers on a cycle where pix_valid & pix_ready; once pix_valid
   // is raised, pix_* hold until that transfer, and the whole pipeline moves together.

   column_state_t state_q, state_d;
   logic          div_start, div_done;
   logic [23:0]   step;

   logic [8:0]  x_q;
   logic [14:0] half_q;
   logic [1:0]  tex_sel_q;
   logic [6:0]  tex_x_q;
   logic [7:0]  ds_q, de_q;
   logic [31:0] tex_pos_q;
   logic [8:0]  row_q;

   logic        s1_valid, s2_valid, s2_fresh;
   logic [7:0]  s1_y, s2_y, s2_data;
   row_kind_t   s1_kind, s2_kind;

   logic              advance, issue, last_accept;
   row_kind_t         row_kind;
   logic [TEX_BITS-1:0] tex_y_cur;
   logic              wide;
   logic [7:0]        setup_ds, setup_de;
   logic [15:0]       setup_off;
   logic              unused_bits;

   assign unused_bits = ^{line_color[7:2], line_height[8:0]};

   column_step_div u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (STEP_DIVIDEND),
      .divisor  (line_height[23:8]),
      .done     (div_done),
      .quotient (step)
   );

   assign busy        = (state_q != IDLE);
   assign dbg_state   = state_q;
   assign advance     = !pix_valid || pix_ready;
   assign issue       = (state_q == EMIT) && advance && (row_q < 9'(SCREEN_H));
   assign last_accept = pix_valid && pix_ready && (pix_y == LAST_ROW);
   assign tex_y_cur   = (|tex_pos_q[31:23]) ? TEX_Y_MAX : tex_pos_q[22:16];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (line_height[23:8] == 16'd0) begin
                  state_d = EMIT;
               end else begin
                  state_d   = DIV;
                  div_start = 1'b1;
               end
            end
         end
         DIV:     if (div_done) state_d = SETUP;
         SETUP:   state_d = EMIT;
         EMIT:    if (last_accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Tall walls clip to the full column and start part-way into the texture.
   always_comb begin
      wide      = half_q >= 15'(HALF_H);
      setup_ds  = HALF_H - half_q[7:0];
      setup_de  = HALF_H - 8'd1 + half_q[7:0];
      setup_off = '0;
      if (wide) begin
         setup_ds  = '0;
         setup_de  = LAST_ROW;
         setup_off = {1'b0, half_q} - 16'(HALF_H);
      end
   end

   always_comb begin
      row_kind = KIND_WALL;
      if (row_q[7:0] < ds_q)      row_kind = KIND_CEIL;
      else if (row_q[7:0] > de_q) row_kind = KIND_FLOOR;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q       <= '0;
         half_q    <= '0;
         tex_sel_q <= '0;
         tex_x_q   <= '0;
         ds_q      <= '0;
         de_q      <= '0;
         tex_pos_q <= '0;
         row_q     <= '0;
         s1_valid  <= 1'b0;
         s1_y      <= '0;
         s1_kind   <= KIND_CEIL;
         tex_addr  <= '0;
         s2_valid  <= 1'b0;
         s2_y      <= '0;
         s2_kind   <= KIND_CEIL;
         s2_fresh  <= 1'b0;
         s2_data   <= '0;
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_color <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            x_q       <= x;
            half_q    <= line_height[23:9];
            tex_sel_q <= line_color[1:0];
            tex_x_q   <= line_tex_x;
            ds_q      <= HALF_H;
            de_q      <= HALF_H - 8'd1;
            tex_pos_q <= '0;
            row_q     <= '0;
         end

         if (state_q == SETUP) begin
            ds_q      <= setup_ds;
            de_q      <= setup_de;
            tex_pos_q <= {16'd0, setup_off} * {8'd0, step};
         end

         // The ROM answers one cycle after s2 loads; a stall parks that answer in s2_data.
         s2_fresh <= (state_q == EMIT) && advance && s1_valid;
         if (s2_fresh) s2_data <= tex_data;

         if (state_q == EMIT && advance) begin
            pix_valid <= s2_valid;
            if (s2_valid) begin
               pix_x <= x_q;
               pix_y <= s2_y;
               case (s2_kind)
                  KIND_CEIL:  pix_color <= CEIL_COLOR;
                  KIND_FLOOR: pix_color <= FLOOR_COLOR;
                  default:    pix_color <= s2_fresh ? tex_data : s2_data;
               endcase
            end
            s2_valid <= s1_valid;
            s2_y     <= s1_y;
            s2_kind  <= s1_kind;
            s1_valid <= issue;
            if (issue) begin
               s1_y     <= row_q[7:0];
               s1_kind  <= row_kind;
               tex_addr <= {tex_sel_q, tex_y_cur, tex_x_q};
               row_q    <= row_q + 9'd1;
               if (row_kind == KIND_WALL) tex_pos_q <= tex_pos_q + {8'd0, step};
            end
         end
      end
   end

endmodule

// File: tb/tb_column_draw.sv
// Directed bench for column_draw: texture ROM model returns tex_y, scoreboard holds
// the expected {x, y, color} stream of every column.
module tb_column_draw;
   import column_draw_pkg::*;

   logic          clk, rst, start;
   logic [8:0]    x;
   logic [23:0]   line_height;
   logic [7:0]    line_color;
   logic [6:0]    line_tex_x;
   logic          busy;
   logic [15:0]   tex_addr;
   logic [7:0]    tex_data;
   logic          pix_valid, pix_ready;
   logic [8:0]    pix_x;
   logic [7:0]    pix_y, pix_color;
   column_state_t dbg_state;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [24:0] exp_q[$];
   logic [7:0]  seen [0:239];
   int          npix, busy_cycles, len1;
   bit          div_seen;
   logic [1:0]  exp_sel;
   logic [6:0]  exp_tx;

   column_draw dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .x           (x),
      .line_height (line_height),
      .line_color  (line_color),
      .line_tex_x  (line_tex_x),
      .busy        (busy),
      .tex_addr    (tex_addr),
      .tex_data    (tex_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_color   (pix_color),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got=running required=finished");
      $fatal(1, "watchdog expired");
   end

   // texture ROM, one cycle read latency
   always @(posedge clk) tex_data <= {1'b0, tex_addr[13:7]};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h required=%0h", tag, got, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (busy) busy_cycles++;
      if (dbg_state == DIV) div_seen = 1'b1;
      if (pix_valid && pix_ready) begin
         npix++;
         if (pix_y < 8'd240) seen[pix_y] = pix_color;
         check("tex_fields", {tex_addr[15:14], tex_addr[6:0]}, {exp_sel, exp_tx});
         if (exp_q.size() == 0) check("queue_has_entry", exp_q.size(), 1);
         else check("pix", {pix_x, pix_y, pix_color}, exp_q.pop_front());
      end
   end

   task automatic push_column(input logic [8:0] cx, input logic [15:0] h);
      int unsigned half, ds, de, step, pos, ty;
      logic [7:0]  c;
      half = h / 2;
      ds   = (half >= 120) ? 0 : 120 - half;
      de   = (half >= 120) ? 239 : 119 + half;
      step = (h == 0) ? 0 : (32'd128 << 16) / h;
      pos  = (ds + half - 120) * step;
      for (int unsigned y = 0; y < 240; y++) begin
         if (y < ds) c = 8'h11;
         else if (y > de) c = 8'h22;
         else begin
            ty  = (pos >= 32'h0080_0000) ? 127 : (pos >> 16);
            c   = ty[7:0];
            pos = pos + step;
         end
         exp_q.push_back({cx, y[7:0], c});
      end
   endtask

   // drivers
   task automatic start_col(input logic [8:0] cx, input logic [23:0] lh,
                            input logic [7:0] lc, input logic [6:0] tx);
      exp_sel = lc[1:0];
      exp_tx  = tx;
      npix    = 0;
      @(posedge clk); #1;
      start = 1'b1; x = cx; line_height = lh; line_color = lc; line_tex_x = tx;
      busy_cycles = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("busy_timeout", ok, 1);
   endtask

   task automatic wait_row(input logic [7:0] row);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (pix_valid && pix_y == row) begin
            ok = 1'b1;
            break;
         end
      end
      check("row_timeout", ok, 1);
   endtask

   task automatic run_column(input logic [8:0] cx, input logic [23:0] lh,
                             input logic [7:0] lc, input logic [6:0] tx);
      push_column(cx, lh[23:8]);
      start_col(cx, lh, lc, tx);
      wait_idle();
      check("pix_count", npix, 240);
      check("queue_empty", exp_q.size(), 0);
   endtask

   task automatic stall_at(input logic [7:0] row, input logic [7:0] color);
      wait_row(row);
      pix_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         check("stall_valid", pix_valid, 1);
         check("stall_y", pix_y, row);
         check("stall_color", pix_color, color);
      end
      pix_ready = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, pix_valid, 0);
      check({tag, "_x"}, pix_x, 0);
      check({tag, "_y"}, pix_y, 0);
      check({tag, "_color"}, pix_color, 0);
      check({tag, "_addr"}, tex_addr, 0);
      check({tag, "_state"}, dbg_state, IDLE);
   endtask

   initial begin
      int dec;
      rst = 1'b0; start = 1'b0; x = '0; line_height = '0; line_color = '0;
      line_tex_x = '0; pix_ready = 1'b1; npix = 0; busy_cycles = 0; div_seen = 1'b0;
      exp_sel = '0; exp_tx = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b1;

      // h=120: step 0x11111, wall rows 60..179
      run_column(9'd10, 24'h007800, 8'hFE, 7'd5);
      len1 = busy_cycles;
      check("h120_row59", seen[59], 8'h11);
      check("h120_row60", seen[60], 8'd0);
      check("h120_row120", seen[120], 8'd63);
      check("h120_row179", seen[179], 8'd126);
      check("h120_row180", seen[180], 8'h22);

      // h=480: whole column is wall, starts at tex_y 31
      run_column(9'd20, 24'h01E000, 8'h01, 7'd100);
      check("h480_row0", seen[0], 8'd31);
      check("h480_row120", seen[120], 8'd63);
      check("h480_row239", seen[239], 8'd95);
      dec = 0;
      for (int y = 1; y < 240; y++) if (seen[y] < seen[y-1]) dec++;
      check("h480_monotonic", dec, 0);
      check("h480_max", seen[239] <= 8'd127, 1);

      // h=0: no wall, divider bypassed
      div_seen = 1'b0;
      run_column(9'd5, 24'h0000FF, 8'h02, 7'd1);
      check("h0_no_div", div_seen, 0);
      check("h0_row0", seen[0], 8'h11);
      check("h0_row119", seen[119], 8'h11);
      check("h0_row120", seen[120], 8'h22);
      check("h0_row239", seen[239], 8'h22);

      // backpressure at row 100 (tex_y 42)
      fork
         run_column(9'd10, 24'h007800, 8'hFE, 7'd5);
         stall_at(8'd100, 8'd42);
      join
      check("stall_busy_len", busy_cycles, len1 + 5);

      // start while busy is ignored
      fork
         run_column(9'd30, 24'h007800, 8'h00, 7'd0);
         begin
            wait_row(8'd50);
            start = 1'b1; x = 9'd31; line_height = 24'h01E000;
            line_color = 8'h03; line_tex_x = 7'd99;
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_start_state", dbg_state, EMIT);
         end
      join
      check("busy_start_len", busy_cycles, len1);
      run_column(9'd31, 24'h007800, 8'h00, 7'd0);

      // reset mid-column at row 50
      push_column(9'd40, 16'd120);
      start_col(9'd40, 24'h007800, 8'h00, 7'd0);
      wait_row(8'd50);
      rst = 1'b0;
      #1;
      check_idle_outputs("midrst");
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      run_column(9'd41, 24'h007800, 8'h01, 7'd3);
      check("midrst_row60", seen[60], 8'd0);
      check("midrst_row179", seen[179], 8'd126);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
